// File: rtl/ahb3lite_modport_slave.sv
// -----------------------------------------------------------------------------
// ahb3lite_modport_slave
//
// Zero-wait-state AHB3-Lite slave wrapping a byte-addressable on-chip SRAM
// (2**MEM_ABITS words of 32 bits).  Supports byte, halfword and word
// transfers; burst type and protection attributes are accepted but ignored
// because the master generates every address.  Illegal sizes (HSIZE>2) and
// misaligned transfers get the standard two-cycle ERROR response.
//
// Ports
//   i_HCLK       bus clock, everything on the rising edge
//   i_HRESETn    asynchronous active-low reset
//   i_HSEL       slave select
//   i_HADDR      byte address (address phase)
//   i_HWDATA     write data (data phase)
//   o_HRDATA     read data, held until the next read completes
//   i_HWRITE     1 = write, 0 = read
//   i_HSIZE      0 byte, 1 half, 2 word, others illegal
//   i_HBURST     burst type, ignored
//   i_HPROT      protection attributes, ignored
//   i_HTRANS     IDLE / BUSY / NONSEQ / SEQ
//   i_HREADY     bus-level ready (this slave's HREADYOUT muxed back)
//   o_HREADYOUT  slave ready
//   o_HRESP      0 OKAY, 1 ERROR
//
// The SRAM array is deliberately not reset: contents survive i_HRESETn.
// -----------------------------------------------------------------------------
module ahb3lite_modport_slave #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int MEM_ABITS  = 10
) (
   input  logic                  i_HCLK,
   input  logic                  i_HRESETn,
   input  logic                  i_HSEL,
   input  logic [HADDR_SIZE-1:0] i_HADDR,
   input  logic [HDATA_SIZE-1:0] i_HWDATA,
   output logic [HDATA_SIZE-1:0] o_HRDATA,
   input  logic                  i_HWRITE,
   input  logic [2:0]            i_HSIZE,
   input  logic [2:0]            i_HBURST,
   input  logic [3:0]            i_HPROT,
   input  logic [1:0]            i_HTRANS,
   input  logic                  i_HREADY,
   output logic                  o_HREADYOUT,
   output logic                  o_HRESP
);

   localparam int MEM_DEPTH = 1 << MEM_ABITS;

   // Error-response FSM encoding
   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_ERR1 = 2'b01;
   localparam logic [1:0] ST_ERR2 = 2'b10;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // A transfer is legal when its size is at most a word and the address is
   // naturally aligned to that size.
   function automatic logic f_legal(input logic [2:0] size, input logic [1:0] lsb);
      logic ok;
      case (size)
         3'd0:    ok = 1'b1;
         3'd1:    ok = ~lsb[0];
         3'd2:    ok = (lsb == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Little-endian byte-lane enables for a (legal) transfer.
   function automatic logic [3:0] f_strb(input logic [2:0] size, input logic [1:0] lsb);
      logic [3:0] strb;
      case (size)
         3'd0:    strb = 4'b0001 << lsb;
         3'd1:    strb = lsb[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

   // Replace the enabled byte lanes of old_w with those of new_w.
   function automatic logic [HDATA_SIZE-1:0] f_merge(input logic [HDATA_SIZE-1:0] old_w,
                                                     input logic [HDATA_SIZE-1:0] new_w,
                                                     input logic [3:0]            strb);
      logic [HDATA_SIZE-1:0] res;
      res = old_w;
      for (int l = 0; l < 4; l++) begin
         if (strb[l]) res[8*l +: 8] = new_w[8*l +: 8];
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;

   logic                  w_accept;
   logic                  w_legal;
   logic [MEM_ABITS-1:0]  w_idx;
   logic [3:0]            w_strb;
   logic [3:0]            w_byp_strb;
   logic [HDATA_SIZE-1:0] w_rd_word;

   logic                  r_wr_pend_p1;
   logic [MEM_ABITS-1:0]  r_idx_p1;
   logic [3:0]            r_strb_p1;
   logic [HDATA_SIZE-1:0] r_hrdata_p1;

   // Burst, protection, the SEQ/NONSEQ distinction and the upper address bits
   // (the address space aliases) carry no meaning for this slave.
   logic                  w_unused;
   assign w_unused = ^{i_HBURST, i_HPROT, i_HTRANS[0], i_HADDR[HADDR_SIZE-1:MEM_ABITS+2]};

   // ---------------------------------------------------------------------------
   // Stage p0: address phase decode
   // ---------------------------------------------------------------------------
   // Nothing is accepted during ERR1 even if a misbehaving bus drives HREADY
   // high there; the master is required to see the first error cycle.
   assign w_accept = i_HSEL & i_HREADY & i_HTRANS[1] & (r_state != ST_ERR1);
   assign w_legal  = f_legal(i_HSIZE, i_HADDR[1:0]);
   assign w_idx    = i_HADDR[MEM_ABITS+1:2];
   assign w_strb   = f_strb(i_HSIZE, i_HADDR[1:0]);

   // A read address phase overlapping the data phase of a write to the same
   // word must see the bytes being written this very edge.
   assign w_byp_strb = (r_wr_pend_p1 && (r_idx_p1 == w_idx)) ? r_strb_p1 : 4'b0000;
   assign w_rd_word  = f_merge(r_mem[w_idx], i_HWDATA, w_byp_strb);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_OK:   if (w_accept && !w_legal) w_state_nxt = ST_ERR1;
         ST_ERR1: w_state_nxt = ST_ERR2;
         ST_ERR2: w_state_nxt = (w_accept && !w_legal) ? ST_ERR1 : ST_OK;
         default: w_state_nxt = ST_OK;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Stage p1: data phase (control, reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_HCLK or negedge i_HRESETn) begin
      if (!i_HRESETn) begin
         r_state      <= ST_OK;
         r_wr_pend_p1 <= 1'b0;
         r_hrdata_p1  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (i_HREADY) begin
            r_wr_pend_p1 <= w_accept & w_legal & i_HWRITE;
         end
         if (w_accept && w_legal && !i_HWRITE) begin
            r_hrdata_p1 <= w_rd_word;
         end
      end
   end

   // Stage p1: data phase (write address/lanes, no reset needed)
   always_ff @(posedge i_HCLK) begin
      if (w_accept) begin
         r_idx_p1  <= w_idx;
         r_strb_p1 <= w_strb;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p2: write commit at the edge ending the write data phase
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_HCLK) begin
      if (r_wr_pend_p1 && i_HREADY) begin
         r_mem[r_idx_p1] <= f_merge(r_mem[r_idx_p1], i_HWDATA, r_strb_p1);
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_HRDATA    = r_hrdata_p1;
   assign o_HREADYOUT = (r_state != ST_ERR1);
   assign o_HRESP     = (r_state != ST_OK);

endmodule

// File: tb/tb_ahb3lite_modport_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb3lite_modport_slave
//
// Self-checking bench for ahb3lite_modport_slave.  A byte-level memory model
// plus an error-phase counter predict HRDATA/HREADYOUT/HRESP; the bench also
// plays the bus multiplexer, driving HREADY from the predicted HREADYOUT.
// Directed scenarios are followed by a randomized transfer stream.
// -----------------------------------------------------------------------------
module tb_ahb3lite_modport_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hready;
   logic        hreadyout;
   logic        hresp;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  mem_m [4096];
   logic [31:0] rdata_m;
   int          err_m;       // 0 OKAY, 1 first error cycle, 2 second error cycle
   logic        pend_m;
   logic [31:0] pend_addr;
   logic [2:0]  pend_size;
   logic [31:0] pend_data;

   always #5 clk = ~clk;

   ahb3lite_modport_slave #(
      .HADDR_SIZE(32),
      .HDATA_SIZE(32),
      .MEM_ABITS (10)
   ) dut (
      .i_HCLK     (clk),
      .i_HRESETn  (rst_n),
      .i_HSEL     (hsel),
      .i_HADDR    (haddr),
      .i_HWDATA   (hwdata),
      .o_HRDATA   (hrdata),
      .i_HWRITE   (hwrite),
      .i_HSIZE    (hsize),
      .i_HBURST   (hburst),
      .i_HPROT    (hprot),
      .i_HTRANS   (htrans),
      .i_HREADY   (hready),
      .o_HREADYOUT(hreadyout),
      .o_HRESP    (hresp)
   );

   function automatic bit legal_m(input logic [2:0] size, input logic [31:0] a);
      if (size > 3'd2) return 1'b0;
      return (int'(a[1:0]) % (1 << int'(size))) == 0;
   endfunction

   function automatic logic [31:0] word_m(input logic [31:0] a);
      int b;
      b = int'(a[11:2]) * 4;
      return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
   endfunction

   // One bus clock: present an address phase (plus the data of any write whose
   // data phase is now), advance the model across the edge, return 1 after it.
   task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                            input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdat);
      logic        acc;
      logic [31:0] wd;
      wd     = pend_m ? pend_data : $urandom;
      hsel   = sel;
      htrans = trans;
      hwrite = wr;
      hsize  = size;
      haddr  = addr;
      hwdata = wd;
      hburst = 3'($urandom);
      hprot  = 4'($urandom);
      hready = (err_m != 1);
      @(posedge clk);
      acc = sel && hready && trans[1];
      if (pend_m) begin
         for (int k = 0; k < (1 << int'(pend_size)); k++) begin
            int ix;
            ix = int'(pend_addr[11:0]) + k;
            mem_m[ix] = wd[8*(ix%4) +: 8];
         end
      end
      pend_m = 1'b0;
      if (err_m == 1) begin
         err_m = 2;
      end else begin
         err_m = (acc && !legal_m(size, addr)) ? 1 : 0;
         if (acc && legal_m(size, addr)) begin
            if (wr) begin
               pend_m    = 1'b1;
               pend_addr = addr;
               pend_size = size;
               pend_data = wdat;
            end else begin
               rdata_m = word_m(addr);
            end
         end
      end
      #1;
   endtask

   task automatic idle_cycle();
      bus_cycle(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hsize  = 3'd0;
      haddr  = '0;
      hwdata = '0;
      hburst = '0;
      hprot  = '0;
      hready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rdata_m = '0;
      err_m   = 0;
      pend_m  = 1'b0;
      checks++;
      if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", hreadyout); end
      checks++;
      if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", hresp); end
      checks++;
      if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 00000000", hrdata); end
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 1024; i++) begin
         bus_cycle(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b1, 3'd2, 32'(i*4), $urandom);
         checks++;
         if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
            errors++;
            $display("FAIL fill_resp word %0d: got rdy=%b resp=%b want rdy=1 resp=0", i, hreadyout, hresp);
         end
      end
      idle_cycle();
   endtask

   task automatic test_word_rw();
      bus_cycle(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      idle_cycle();
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
      checks++;
      if (hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read: got %h want deadbeef", hrdata); end
      checks++;
      if (hresp !== 1'b0 || hreadyout !== 1'b1) begin
         errors++; $display("FAIL word_read_resp: got rdy=%b resp=%b want rdy=1 resp=0", hreadyout, hresp);
      end
      repeat (3) idle_cycle();
      checks++;
      if (hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read_hold: got %h want deadbeef", hrdata); end
   endtask

   task automatic test_byte_half();
      bus_cycle(1'b1, 2'b10, 1'b1, 3'd0, 32'h13, {8'hA5, 24'($urandom)});
      bus_cycle(1'b1, 2'b10, 1'b1, 3'd1, 32'h10, {16'($urandom), 16'h1234});
      idle_cycle();
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
      checks++;
      if (hrdata !== 32'hA5AD1234) begin errors++; $display("FAIL byte_half_word: got %h want a5ad1234", hrdata); end
      // A byte read still returns the whole word.
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd0, 32'h12, 32'h0);
      checks++;
      if (hrdata !== 32'hA5AD1234) begin errors++; $display("FAIL byte_read_full: got %h want a5ad1234", hrdata); end
   endtask

   task automatic test_back_to_back();
      bus_cycle(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h11223344);
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
      checks++;
      if (hrdata !== 32'h11223344) begin errors++; $display("FAIL b2b_word: got %h want 11223344", hrdata); end
      // Partial-lane bypass: only lane 1 comes from the in-flight write.
      bus_cycle(1'b1, 2'b10, 1'b1, 3'd0, 32'h21, 32'hFFFF77FF);
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
      checks++;
      if (hrdata !== 32'h11227744) begin errors++; $display("FAIL b2b_byte: got %h want 11227744", hrdata); end
      idle_cycle();
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
      checks++;
      if (hrdata !== 32'h11227744) begin errors++; $display("FAIL b2b_commit: got %h want 11227744", hrdata); end
   endtask

   task automatic test_error();
      logic [31:0] w0;
      logic [31:0] hr;
      w0 = word_m(32'h0);
      hr = hrdata;
      bus_cycle(1'b1, 2'b10, 1'b1, 3'd2, 32'h2, 32'h5A5A5A5A);
      checks++;
      if (hreadyout !== 1'b0 || hresp !== 1'b1) begin
         errors++; $display("FAIL err1_misaligned: got rdy=%b resp=%b want rdy=0 resp=1", hreadyout, hresp);
      end
      bus_cycle(1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
      checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b1) begin
         errors++; $display("FAIL err2_misaligned: got rdy=%b resp=%b want rdy=1 resp=1", hreadyout, hresp);
      end
      checks++;
      if (hrdata !== hr) begin errors++; $display("FAIL err_hrdata_hold: got %h want %h", hrdata, hr); end
      idle_cycle();
      checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
         errors++; $display("FAIL err_recover: got rdy=%b resp=%b want rdy=1 resp=0", hreadyout, hresp);
      end
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0);
      checks++;
      if (hrdata !== w0) begin errors++; $display("FAIL err_no_write: got %h want %h", hrdata, w0); end
      // Illegal size on a read.
      hr = w0;
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd3, 32'h4, 32'h0);
      checks++;
      if (hreadyout !== 1'b0 || hresp !== 1'b1 || hrdata !== hr) begin
         errors++; $display("FAIL err1_size3: got rdy=%b resp=%b rd=%h want rdy=0 resp=1 rd=%h", hreadyout, hresp, hrdata, hr);
      end
      bus_cycle(1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
      checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b1 || hrdata !== hr) begin
         errors++; $display("FAIL err2_size3: got rdy=%b resp=%b rd=%h want rdy=1 resp=1 rd=%h", hreadyout, hresp, hrdata, hr);
      end
      // A legal read presented during ERR2 is accepted.
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
      checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h11227744) begin
         errors++; $display("FAIL err2_accept: got rdy=%b resp=%b rd=%h want rdy=1 resp=0 rd=11227744", hreadyout, hresp, hrdata);
      end
      // Odd-address halfword, then another illegal right in ERR2.
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd1, 32'h31, 32'h0);
      bus_cycle(1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
      bus_cycle(1'b1, 2'b10, 1'b1, 3'd2, 32'h33, 32'h0);
      checks++;
      if (hreadyout !== 1'b0 || hresp !== 1'b1) begin
         errors++; $display("FAIL err_in_err2: got rdy=%b resp=%b want rdy=0 resp=1", hreadyout, hresp);
      end
      idle_cycle();
      idle_cycle();
   endtask

   task automatic test_nosel();
      logic [31:0] w40;
      w40 = word_m(32'h40);
      bus_cycle(1'b0, 2'b10, 1'b1, 3'd2, 32'h40, ~w40);
      bus_cycle(1'b1, 2'b00, 1'b1, 3'd2, 32'h40, ~w40);
      bus_cycle(1'b1, 2'b01, 1'b1, 3'd2, 32'h40, ~w40);
      checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
         errors++; $display("FAIL nosel_resp: got rdy=%b resp=%b want rdy=1 resp=0", hreadyout, hresp);
      end
      idle_cycle();
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
      checks++;
      if (hrdata !== w40) begin errors++; $display("FAIL nosel_unchanged: got %h want %h", hrdata, w40); end
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h1040, 32'h0);
      checks++;
      if (hrdata !== w40) begin errors++; $display("FAIL alias_read: got %h want %h", hrdata, w40); end
      bus_cycle(1'b1, 2'b10, 1'b1, 3'd2, 32'h1040, 32'hCAFEF00D);
      idle_cycle();
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
      checks++;
      if (hrdata !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_write: got %h want cafef00d", hrdata); end
   endtask

   task automatic test_async_reset();
      logic [31:0] old;
      old = word_m(32'h80);
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h84, 32'h0);
      bus_cycle(1'b1, 2'b10, 1'b1, 3'd2, 32'h80, ~old);
      // Mid data phase of the write: assert reset away from any edge.
      hwdata = pend_data;
      hsel   = 1'b0;
      htrans = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      pend_m  = 1'b0;
      rdata_m = '0;
      err_m   = 0;
      checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
         errors++; $display("FAIL async_rst_outputs: got rdy=%b resp=%b rd=%h want 1 0 00000000", hreadyout, hresp, hrdata);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd2, 32'h80, 32'h0);
      checks++;
      if (hrdata !== old) begin errors++; $display("FAIL async_rst_drop_write: got %h want %h", hrdata, old); end
      // Reset during ERR1 releases HREADYOUT immediately.
      bus_cycle(1'b1, 2'b10, 1'b0, 3'd7, 32'h0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      err_m   = 0;
      rdata_m = '0;
      checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
         errors++; $display("FAIL async_rst_err1: got rdy=%b resp=%b want rdy=1 resp=0", hreadyout, hresp);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random(input int n);
      for (int c = 0; c < n; c++) begin
         logic        s;
         logic [1:0]  t;
         logic        w;
         logic [2:0]  sz;
         logic [31:0] a;
         s  = ($urandom_range(9) != 0);
         t  = 2'($urandom);
         w  = 1'($urandom);
         sz = ($urandom_range(7) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
         a  = $urandom;
         if ($urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         bus_cycle(s, t, w, sz, a, $urandom);
         checks++;
         if (hreadyout !== (err_m != 1)) begin
            errors++; $display("FAIL rnd_hreadyout cycle %0d: got %b want %b", c, hreadyout, (err_m != 1));
         end
         checks++;
         if (hresp !== (err_m != 0)) begin
            errors++; $display("FAIL rnd_hresp cycle %0d: got %b want %b", c, hresp, (err_m != 0));
         end
         checks++;
         if (hrdata !== rdata_m) begin
            errors++; $display("FAIL rnd_hrdata cycle %0d: got %h want %h", c, hrdata, rdata_m);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_word_rw();
      test_byte_half();
      test_back_to_back();
      test_error();
      test_nosel();
      test_async_reset();
      test_random(3000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
